commit_sequencer: RTL and testbench

- Retires ROB head entries in order, at most one per cycle.
- Drives the register file commit port (rd, result, ROB label) so the file can write the value and clear a matching rename label.
- Sequences store retirement through a store handshake.
- On a committed mispredicted branch, raises the pipeline flush and PC redirect, then holds retirement for a fixed recovery window.

---
 rtl/commit_sequencer.sv | 136 +++++++++++++
 tb/tb_commit_sequencer.sv | 122 ++++++++++++
 2 files changed

// File: rtl/commit_sequencer.sv
// In-order retirement of the ROB head: register-file commit, store handshake,
// and mispredict flush/redirect followed by a fixed recovery window.
module commit_sequencer #(
  parameter int ROB_ID_WIDTH = 4,
  parameter int REG_WIDTH    = 5,
  parameter int VAL_WIDTH    = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    head_valid,
  input  logic [ROB_ID_WIDTH:0]   head_tag,
  input  logic [REG_WIDTH-1:0]    head_rd,
  input  logic [VAL_WIDTH-1:0]    head_res,
  input  logic                    head_is_store,
  input  logic                    head_is_branch,
  input  logic                    head_mispred,
  input  logic [31:0]             head_target,
  output logic                    head_ready,
  output logic                    store_go,
  input  logic                    store_done,
  output logic                    rf_commit_en,
  output logic [REG_WIDTH-1:0]    rf_commit_rd,
  output logic [VAL_WIDTH-1:0]    rf_commit_res,
  output logic [ROB_ID_WIDTH:0]   rf_commit_lab,
  output logic                    flush,
  output logic                    pc_redirect_en,
  output logic [31:0]             pc_redirect,
  output logic [31:0]             commit_count
);

  typedef enum logic [1:0] {IDLE, STORE_WAIT, FLUSH} state_t;

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

  state_t                  state_reg, state_next;
  logic [3:0]              flush_cnt_reg, flush_cnt_next;
  logic                    store_go_reg, store_go_next;
  logic                    retire, mispred;
  logic                    rf_commit_en_reg;
  logic [REG_WIDTH-1:0]    rf_commit_rd_reg;
  logic [VAL_WIDTH-1:0]    rf_commit_res_reg;
  logic [ROB_ID_WIDTH:0]   rf_commit_lab_reg;
  logic                    flush_reg, pc_redirect_en_reg;
  logic [31:0]             pc_redirect_reg, commit_count_reg;

  always_comb begin
    state_next     = state_reg;
    flush_cnt_next = flush_cnt_reg;
    store_go_next  = store_go_reg;
    retire         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (head_valid) begin
          if (head_is_store) begin
            store_go_next = 1'b1;
            state_next    = STORE_WAIT;
          end else begin
            retire = 1'b1;
          end
        end
      end
      STORE_WAIT: begin
        if (store_done) begin
          retire        = 1'b1;
          store_go_next = 1'b0;
          state_next    = IDLE;
        end
      end
      FLUSH: begin
        flush_cnt_next = flush_cnt_reg - 4'd1;
        if (flush_cnt_reg <= 4'd1) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // A stalled or resetting cycle must never pop the ROB.
    if (rst_in || !rdy_in) retire = 1'b0;
    mispred = retire && head_is_branch && head_mispred;
    if (mispred) begin
      state_next     = FLUSH;
      flush_cnt_next = FLUSH_INIT;
    end
  end

  assign head_ready = retire;

  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_reg          <= IDLE;
      flush_cnt_reg      <= '0;
      store_go_reg       <= 1'b0;
      rf_commit_en_reg   <= 1'b0;
      rf_commit_rd_reg   <= '0;
      rf_commit_res_reg  <= '0;
      rf_commit_lab_reg  <= '0;
      flush_reg          <= 1'b0;
      pc_redirect_en_reg <= 1'b0;
      pc_redirect_reg    <= '0;
      commit_count_reg   <= '0;
    end else begin
      // Strobes default low so a stall never repeats a pulse.
      rf_commit_en_reg   <= 1'b0;
      flush_reg          <= 1'b0;
      pc_redirect_en_reg <= 1'b0;
      if (rdy_in) begin
        state_reg     <= state_next;
        flush_cnt_reg <= flush_cnt_next;
        store_go_reg  <= store_go_next;
        if (retire) begin
          rf_commit_en_reg  <= (head_rd != '0) && !head_is_store;
          rf_commit_rd_reg  <= head_rd;
          rf_commit_res_reg <= head_res;
          rf_commit_lab_reg <= head_tag;
          commit_count_reg  <= commit_count_reg + 32'd1;
        end
        if (mispred) begin
          flush_reg          <= 1'b1;
          pc_redirect_en_reg <= 1'b1;
          pc_redirect_reg    <= head_target;
        end
      end
    end
  end

  assign store_go       = store_go_reg;
  assign rf_commit_en   = rf_commit_en_reg;
  assign rf_commit_rd   = rf_commit_rd_reg;
  assign rf_commit_res  = rf_commit_res_reg;
  assign rf_commit_lab  = rf_commit_lab_reg;
  assign flush          = flush_reg;
  assign pc_redirect_en = pc_redirect_en_reg;
  assign pc_redirect    = pc_redirect_reg;
  assign commit_count   = commit_count_reg;

endmodule

// File: tb/tb_commit_sequencer.sv
// Randomized bench for commit_sequencer: a ROB head model supplies entries and a
// behavioural retirement model predicts every output each cycle.
module tb_commit_sequencer;
  localparam int FLUSH_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst_in = 1'b1, rdy_in = 1'b0, head_valid = 1'b0;
  logic [4:0]  head_tag = 5'd1, head_rd = '0;
  logic [31:0] head_res = '0, head_target = '0;
  logic        head_is_store = 1'b0, head_is_branch = 1'b0, head_mispred = 1'b0;
  logic        store_done = 1'b0;
  logic        head_ready, store_go, rf_commit_en, flush, pc_redirect_en;
  logic [4:0]  rf_commit_rd, rf_commit_lab;
  logic [31:0] rf_commit_res, pc_redirect, commit_count;

  commit_sequencer #(.ROB_ID_WIDTH(4), .REG_WIDTH(5), .VAL_WIDTH(32),
                     .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .head_valid(head_valid),
    .head_tag(head_tag), .head_rd(head_rd), .head_res(head_res),
    .head_is_store(head_is_store), .head_is_branch(head_is_branch),
    .head_mispred(head_mispred), .head_target(head_target),
    .head_ready(head_ready), .store_go(store_go), .store_done(store_done),
    .rf_commit_en(rf_commit_en), .rf_commit_rd(rf_commit_rd),
    .rf_commit_res(rf_commit_res), .rf_commit_lab(rf_commit_lab),
    .flush(flush), .pc_redirect_en(pc_redirect_en), .pc_redirect(pc_redirect),
    .commit_count(commit_count));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [4:0]  tag;
    logic [4:0]  rd;
    logic [31:0] res;
    bit          st, br, mp;
    logic [31:0] tgt;
  } ent_t;

  function automatic ent_t new_entry();
    ent_t e;
    e.tag = 5'($urandom_range(1, 31));
    e.rd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    e.res = $urandom;
    e.st  = ($urandom_range(0, 4) == 0);
    e.br  = !e.st && ($urandom_range(0, 3) == 0);
    e.mp  = e.br && ($urandom_range(0, 1) == 1);
    e.tgt = $urandom;
    return e;
  endfunction

  // Model: "store issued" flag, cycles of retirement still blocked by a flush,
  // and the expected values of every registered output.
  bit          m_store_issued = 0;
  int          m_blocked = 0;
  bit          x_en = 0, x_flush = 0, x_redir_en = 0;
  logic [4:0]  x_rd = '0, x_lab = '0;
  logic [31:0] x_res = '0, x_redir = '0, x_count = '0;
  bit          x_ready;
  ent_t        cur;

  initial begin
    cur = new_entry();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      rst_in     = (cyc < 2) || ($urandom_range(0, 99) < 2);
      rdy_in     = ($urandom_range(0, 99) < 85);
      head_valid = m_store_issued || ($urandom_range(0, 99) < 80);
      store_done = ($urandom_range(0, 99) < 40);
      head_tag = cur.tag; head_rd = cur.rd; head_res = cur.res;
      head_is_store = cur.st; head_is_branch = cur.br;
      head_mispred = cur.mp; head_target = cur.tgt;
      #1;
      x_ready = !rst_in && rdy_in && (m_blocked == 0) &&
                (m_store_issued ? store_done : (head_valid && !cur.st));
      check_eq("head_ready", 32'(head_ready), 32'(x_ready));
      check_eq("store_go", 32'(store_go), 32'(m_store_issued));
      check_eq("rf_commit_en", 32'(rf_commit_en), 32'(x_en));
      check_eq("rf_commit_rd", 32'(rf_commit_rd), 32'(x_rd));
      check_eq("rf_commit_res", rf_commit_res, x_res);
      check_eq("rf_commit_lab", 32'(rf_commit_lab), 32'(x_lab));
      check_eq("flush", 32'(flush), 32'(x_flush));
      check_eq("pc_redirect_en", 32'(pc_redirect_en), 32'(x_redir_en));
      check_eq("pc_redirect", pc_redirect, x_redir);
      check_eq("commit_count", commit_count, x_count);

      x_en = 0; x_flush = 0; x_redir_en = 0;
      if (rst_in) begin
        m_store_issued = 0; m_blocked = 0;
        x_rd = '0; x_lab = '0; x_res = '0; x_redir = '0; x_count = '0;
        cur = new_entry();
      end else if (rdy_in) begin
        if (m_blocked > 0) begin
          m_blocked--;
        end else if (x_ready) begin
          x_en = (cur.rd != 0) && !cur.st;
          x_rd = cur.rd; x_res = cur.res; x_lab = cur.tag;
          x_count = x_count + 1;
          m_store_issued = 0;
          if (cur.br && cur.mp) begin
            x_flush = 1; x_redir_en = 1; x_redir = cur.tgt;
            m_blocked = FLUSH_CYCLES;
          end
          cur = new_entry();
        end else if (head_valid && cur.st) begin
          m_store_issued = 1;
        end
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
